psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Sequential accumulation stage directly downstream of the 4-bit ripple-carry adder in the TPU datapath. Accepts a stream of unsigned adder results (IN_W bits, carry-out included), sums a fixed group of ACC_LEN consecutive terms into a wider register, and presents each completed partial sum on a valid/ready output. Feeds the output buffer / activation stage.

## Interface
- IN_W, 5: input term width (adder sum incl. carry-out).
- ACC_W, 12: accumulator and output width; must be ≥ IN_W.
- ACC_LEN, 4: terms per result; ≥ 1.

- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of current group.
- in_valid  in  1  upstream term valid.
- in_ready  out  1  block can accept a term this cycle.
- in_data  in  IN_W  unsigned term.
- out_valid  out  1  completed result held.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  accumulated sum.
- out_overflow  out  1  result exceeded 2^ACC_W−1 at some point in the group.

## Operation
- Transfer on a port occurs when valid && ready at a rising edge.
- States: IDLE, ACCUM, HOLD; registers acc[ACC_W], cnt[clog2(ACC_LEN+1)], ovf.
- IDLE: in_ready=1, out_valid=0. On accept: acc←zero-extended in_data, cnt←1, ovf←0; next HOLD if ACC_LEN==1 else ACCUM.
- ACCUM: in_ready=1. On accept: acc←acc+in_data, cnt←cnt+1; if cnt+1==ACC_LEN → HOLD. No accept → hold state.
- HOLD: out_valid=1, out_data=acc, out_overflow=ovf; in_ready=out_ready.
  - out_ready && !in_valid → IDLE.
  - out_ready && in_valid → new group starts same edge (as IDLE accept); no bubble.
  - !out_ready → out_data/out_overflow stable; no input accepted.
- Add is ACC_W+1 bits wide; carry out sets ovf (sticky for the group). Result bits: see Configuration.
- flush (highest priority after rst): state←IDLE, acc←0, cnt←0, ovf←0; in_ready and out_valid forced 0 during the flush cycle; held result is discarded.
- in_data ignored when no transfer occurs.

## Timing
- Reset values: state IDLE, acc 0, cnt 0, ovf 0 → in_ready=1, out_valid=0, out_data=0, out_overflow=0 (in_ready 0 while rst asserted).
- Reset mid-group or mid-HOLD: immediate return to reset values; partial sum lost.
- Latency: out_valid rises the cycle after the ACC_LEN-th term is accepted.
- Peak throughput: one term per cycle; one result per ACC_LEN cycles sustained when out_ready held high.
- in_ready depends combinationally on out_ready in HOLD only; out_valid and out_data are register-driven.
- cnt never exceeds ACC_LEN; wraps to 0/1 only via group restart.

## Configuration
- PSUM_ACC_SATURATE_EN defined: on carry out, acc←2^ACC_W−1 and remains clamped for the rest of the group; ovf set.
- Undefined: acc wraps modulo 2^ACC_W; ovf still set. Result is the wrapped sum.

## Structure
- Shared package tpu_pkg: state enum psum_state_t {IDLE, ACCUM, HOLD}; default width constants (adder sum width 5) reused by adder and accumulator.
- One natural sub-module: psum_term_counter (cnt register, increment, load-1, clear, terminal flag cnt+1==ACC_LEN). Adder/saturate logic stays inline.

## Test plan
- Reset release, defaults: terms 3,5,7,9 on consecutive cycles, out_ready=1 → out_valid one cycle after 4th term, out_data=24, out_overflow=0, then IDLE.
- Backpressure: complete group 1,1,1,1 with out_ready=0 for 5 cycles → out_data=4 stable, in_ready=0, in_valid terms not consumed; on out_ready=1 with in_valid=1, term 2 accepted same edge and starts next group.
- Overflow, ACC_W=6: terms 31,31,31,31 → without macro out_data=124 mod 64=60, out_overflow=1; with PSUM_ACC_SATURATE_EN out_data=63, out_overflow=1.
- Flush after 2 terms (10,10), then terms 1,2,3,4 → result 10, no stale contribution; flush during HOLD drops out_valid next cycle.
- Async rst asserted mid-group (between clock edges) → outputs reach reset values without a clock edge; subsequent group 2,2,2,2 yields 8.
- ACC_LEN=1: terms 17,18 back-to-back with out_ready=1 → results 17 and 18 on consecutive cycles, no bubble.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU datapath types and default widths.
// Used by the 4-bit adder and the partial-sum accumulator.
package tpu_pkg;

  localparam int ADD_SUM_W    = 5;
  localparam int PSUM_ACC_W   = 12;
  localparam int PSUM_ACC_LEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } psum_state_t;

endpackage

// File: rtl/psum_accumulator_term_counter.sv
// Term counter for psum_accumulator: load-1, increment, clear.
// last flags that the next accepted term completes the group.
module psum_term_counter
  import tpu_pkg::*;
#(
  parameter int ACC_LEN = PSUM_ACC_LEN,
  parameter int CW      = $clog2(ACC_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (int'(cnt) + 1) == ACC_LEN;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(1);
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums ACC_LEN adder results per group.
// Define PSUM_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module psum_accumulator
  import tpu_pkg::*;
#(
  parameter int IN_W    = ADD_SUM_W,
  parameter int ACC_W   = PSUM_ACC_W,
  parameter int ACC_LEN = PSUM_ACC_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_overflow
);

  localparam int CW = $clog2(ACC_LEN + 1);

  psum_state_t      state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             in_fire;
  logic             start;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] nxt_acc;
  logic [ACC_W-1:0] first;

  assign in_ready  = !rst && !flush
                   && (state != HOLD || out_ready);
  assign out_valid = (state == HOLD) && !flush;
  assign out_data     = acc;
  assign out_overflow = ovf;

  assign in_fire = in_valid && in_ready;
  // IDLE accept and HOLD pass-through both open a fresh group
  assign start   = in_fire && (state != ACCUM);
  assign first   = ACC_W'(in_data);
  assign sum     = {1'b0, acc} + (ACC_W + 1)'(in_data);
  assign carry   = sum[ACC_W];

`ifdef PSUM_ACC_SATURATE_EN
  assign nxt_acc = (carry || ovf) ? '1 : sum[ACC_W-1:0];
`else
  assign nxt_acc = sum[ACC_W-1:0];
`endif

  psum_term_counter #(
    .ACC_LEN (ACC_LEN),
    .CW      (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .load  (start),
    .inc   (in_fire && state == ACCUM),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (start) begin
            acc   <= first;
            ovf   <= 1'b0;
            state <= (ACC_LEN == 1) ? HOLD : ACCUM;
          end else if (state == HOLD && out_ready) begin
            state <= IDLE;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc <= nxt_acc;
            ovf <= ovf | carry;
            if (last) state <= HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: three configurations share one stimulus
// stream and are checked against an unbounded-sum group model.
module tb_psum_accumulator;

  localparam int AW [3] = '{12, 6, 12};
  localparam int AL [3] = '{4, 4, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [4:0] in_data;
  logic       out_ready;

  logic        ir [3];
  logic        ov [3];
  logic        of [3];
  logic [11:0] od [3];
  logic [11:0] od0;
  logic [5:0]  od1;
  logic [11:0] od2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  psum_accumulator #(.IN_W(5), .ACC_W(12), .ACC_LEN(4)) u0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od0), .out_overflow(of[0])
  );

  psum_accumulator #(.IN_W(5), .ACC_W(6), .ACC_LEN(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od1), .out_overflow(of[1])
  );

  psum_accumulator #(.IN_W(5), .ACC_W(12), .ACC_LEN(1)) u2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od2), .out_overflow(of[2])
  );

  assign od[0] = od0;
  assign od[1] = {6'b0, od1};
  assign od[2] = od2;

  // Model: a group is the list of accepted terms; keep their exact sum.
  typedef struct {
    bit     hold;
    int     n;
    longint sum;
  } ms_t;

  ms_t m [3];

  function automatic ms_t m_clear();
    ms_t r;
    r.hold = 1'b0;
    r.n    = 0;
    r.sum  = 0;
    return r;
  endfunction

  function automatic ms_t m_step(ms_t s, int al, bit iv, bit ordy,
                                 logic [4:0] d);
    ms_t r = s;
    if (s.hold && ordy) r = m_clear();
    if (iv && (!s.hold || ordy)) begin
      r.sum = r.sum + longint'(d);
      r.n   = r.n + 1;
      if (r.n == al) r.hold = 1'b1;
    end
    return r;
  endfunction

  function automatic longint e_data(longint s, int aw);
    longint mx = (longint'(1) << aw) - 1;
`ifdef PSUM_ACC_SATURATE_EN
    return (s > mx) ? mx : s;
`else
    return s & mx;
`endif
  endfunction

  function automatic longint e_ovf(longint s, int aw);
    return longint'(s > ((longint'(1) << aw) - 1));
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst || flush) m[k] <= m_clear();
      else m[k] <= m_step(m[k], AL[k], in_valid, out_ready, in_data);
    end
  end

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cmp%0d_in_ready", k), longint'(ir[k]),
          longint'(!rst && !flush && (!m[k].hold || out_ready)));
      chk($sformatf("cmp%0d_out_valid", k), longint'(ov[k]),
          longint'(m[k].hold && !flush && !rst));
      if (ov[k] && m[k].hold) begin
        chk($sformatf("cmp%0d_out_data", k), longint'(od[k]),
            e_data(m[k].sum, AW[k]));
        chk($sformatf("cmp%0d_overflow", k), longint'(of[k]),
            e_ovf(m[k].sum, AW[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int d);
    step();
    in_valid = 1'b1;
    in_data  = 5'(d);
  endtask

  task automatic feed4(input int a, input int b, input int c,
                       input int d);
    feed(a);
    feed(b);
    feed(c);
    feed(d);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", longint'(ir[0]), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_rel", longint'(ir[0]), 1);
    chk("rst_out_valid", longint'(ov[0]), 0);
    chk("rst_out_data", longint'(od[0]), 0);
    chk("rst_overflow", longint'(of[0]), 0);

    out_ready = 1'b1;
    feed4(3, 5, 7, 9);
    @(negedge clk);
    chk("t1_valid", longint'(ov[0]), 1);
    chk("t1_data", longint'(od[0]), 24);
    chk("t1_ovf", longint'(of[0]), 0);
    chk("t1_model", m[0].sum, 24);
    step();
    @(negedge clk);
    chk("t1_idle", longint'(ov[0]), 0);

    out_ready = 1'b0;
    feed4(1, 1, 1, 1);
    in_valid = 1'b1;
    in_data  = 5'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", longint'(od[0]), 4);
      chk("bp_in_ready", longint'(ir[0]), 0);
      chk("bp_valid", longint'(ov[0]), 1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", longint'(ir[0]), 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_no_bubble", longint'(ov[0]), 0);
    feed(0);
    feed(0);
    feed(0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", longint'(ov[0]), 1);
    chk("bp_next_data", longint'(od[0]), 2);

    feed4(31, 31, 31, 31);
    @(negedge clk);
`ifdef PSUM_ACC_SATURATE_EN
    chk("ovf6_data", longint'(od[1]), 63);
`else
    chk("ovf6_data", longint'(od[1]), 60);
`endif
    chk("ovf6_flag", longint'(of[1]), 1);
    chk("ovf12_data", longint'(od[0]), 124);
    chk("ovf12_flag", longint'(of[0]), 0);

    feed(10);
    feed(10);
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    feed4(1, 2, 3, 4);
    @(negedge clk);
    chk("fl_valid", longint'(ov[0]), 1);
    chk("fl_data", longint'(od[0]), 10);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_hold_valid", longint'(ov[0]), 0);
    chk("fl_hold_ready", longint'(ir[0]), 0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_after_valid", longint'(ov[0]), 0);
    out_ready = 1'b1;

    feed(2);
    feed(2);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ar_partial", longint'(od[0]), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_data", longint'(od[0]), 0);
    chk("ar_valid", longint'(ov[0]), 0);
    chk("ar_ready", longint'(ir[0]), 0);
    chk("ar_ovf", longint'(of[0]), 0);
    step();
    rst = 1'b0;
    feed4(2, 2, 2, 2);
    @(negedge clk);
    chk("ar_group_valid", longint'(ov[0]), 1);
    chk("ar_group_data", longint'(od[0]), 8);

    feed(17);
    feed(18);
    @(negedge clk);
    chk("len1_a_valid", longint'(ov[2]), 1);
    chk("len1_a_data", longint'(od[2]), 17);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("len1_b_valid", longint'(ov[2]), 1);
    chk("len1_b_data", longint'(od[2]), 18);

    for (int i = 0; i < 3000; i++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rst       = ($urandom_range(0, 199) == 0);
    end
    step();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
